amdemod: RTL and testbench

AMDEMOD -- requirements
Module: amdemod

---
 rtl/amdemod.sv | 218 +++++++++++++++++++++
 tb/tb_amdemod.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/amdemod.sv
// AM demodulator: mixes NSLICE ADC samples/clock with exp(-j*phi), accumulates I/Q over an nsamp-clock window.
// Latency: result registered 4 clocks after the last window sample (gateout at edge t0+nsamp+4).
// No backpressure: gatein during a capture is dropped and flagged by a one-cycle overrun pulse.
// Build option: define AMDEMOD_SATURATE_EN to clamp the accumulators and report sat; otherwise they wrap.
module amdemod #(
  parameter int NSLICE = 4,
  parameter int AW     = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gatein,
  input  logic [15:0]            nsamp,
  input  logic [NSLICE*16-1:0]   adcx16,
  input  logic [NSLICE*16-1:0]   locos16,
  input  logic [NSLICE*16-1:0]   losin16,
  output logic [AW-1:0]          iout,
  output logic [AW-1:0]          qout,
  output logic                   gateout,
  output logic                   busy,
  output logic                   overrun,
  output logic                   sat
);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t        state;
  logic [15:0]   rem;
  logic          first_pend;

  // stage 1: input register and window tags
  logic [NSLICE*16-1:0] s1_adc, s1_cos, s1_sin;
  logic                 s1_vld, s1_first, s1_last;
  // stage 2: per-slice products
  logic [31:0]          s2_pi [NSLICE];
  logic [31:0]          s2_pq [NSLICE];
  logic                 s2_vld, s2_first, s2_last;
  // stage 3: per-clock slice sums, already sign-extended to AW
  logic [AW-1:0]        sum_i, sum_q;
  logic [AW-1:0]        s3_i, s3_q;
  logic                 s3_vld, s3_first, s3_last;
  // stage 4: accumulators
  logic [AW-1:0]        acc_i, acc_q;
  logic                 acc_sat;
  logic                 s4_last;
  logic [AW-1:0]        nxt_i, nxt_q;
  logic                 nxt_sat;

  // Window FSM: latches nsamp at t0, tags each captured clock, flags dropped gateins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      first_pend <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      s1_vld     <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (gatein && (nsamp != 16'd0)) begin
            state      <= CAPTURE;
            busy       <= 1'b1;
            rem        <= nsamp;
            first_pend <= 1'b1;
          end
        end
        CAPTURE: begin
          overrun    <= gatein;
          s1_vld     <= 1'b1;
          s1_first   <= first_pend;
          first_pend <= 1'b0;
          s1_last    <= (rem == 16'd1);
          rem        <= rem - 16'd1;
          if (rem == 16'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: register the sample and LO buses every clock; tags decide whether they count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_adc <= '0;
      s1_cos <= '0;
      s1_sin <= '0;
    end else begin
      s1_adc <= adcx16;
      s1_cos <= locos16;
      s1_sin <= losin16;
    end
  end

  // Stage 2: full-precision signed products; low 32 bits of the sign-extended product are exact
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NSLICE; k++) begin
        s2_pi[k] <= '0;
        s2_pq[k] <= '0;
      end
      s2_vld   <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      for (int k = 0; k < NSLICE; k++) begin
        s2_pi[k] <= {{16{s1_adc[16*k+15]}}, s1_adc[16*k +: 16]} *
                    {{16{s1_cos[16*k+15]}}, s1_cos[16*k +: 16]};
        s2_pq[k] <= {{16{s1_adc[16*k+15]}}, s1_adc[16*k +: 16]} *
                    {{16{s1_sin[16*k+15]}}, s1_sin[16*k +: 16]};
      end
      s2_vld   <= s1_vld;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  // Slice sums, each product sign-extended to AW so no precision is lost
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < NSLICE; k++) begin
      sum_i = sum_i + {{(AW-32){s2_pi[k][31]}}, s2_pi[k]};
      sum_q = sum_q + {{(AW-32){s2_pq[k][31]}}, s2_pq[k]};
    end
  end

  // Stage 3: register slice sums; Q is negated here to mix with exp(-j*phi)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_i     <= '0;
      s3_q     <= '0;
      s3_vld   <= 1'b0;
      s3_first <= 1'b0;
      s3_last  <= 1'b0;
    end else begin
      s3_i     <= sum_i;
      s3_q     <= -sum_q;
      s3_vld   <= s2_vld;
      s3_first <= s2_first;
      s3_last  <= s2_last;
    end
  end

`ifdef AMDEMOD_SATURATE_EN
  logic [AW:0]   add_i, add_q;
  logic          ovf_i, ovf_q;
  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  // Saturating add: one guard bit detects overflow, clamp toward the sign of the true sum
  always_comb begin
    add_i   = {acc_i[AW-1], acc_i} + {s3_i[AW-1], s3_i};
    add_q   = {acc_q[AW-1], acc_q} + {s3_q[AW-1], s3_q};
    ovf_i   = add_i[AW] ^ add_i[AW-1];
    ovf_q   = add_q[AW] ^ add_q[AW-1];
    nxt_i   = ovf_i ? (add_i[AW] ? ACC_MIN : ACC_MAX) : add_i[AW-1:0];
    nxt_q   = ovf_q ? (add_q[AW] ? ACC_MIN : ACC_MAX) : add_q[AW-1:0];
    nxt_sat = ovf_i | ovf_q;
  end
`else
  // Wrapping add modulo 2^AW; saturation can never be reported
  always_comb begin
    nxt_i   = acc_i + s3_i;
    nxt_q   = acc_q + s3_q;
    nxt_sat = 1'b0;
  end
`endif

  // Stage 4: first-sample tag loads the accumulator, so no explicit clear between windows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_i   <= '0;
      acc_q   <= '0;
      acc_sat <= 1'b0;
      s4_last <= 1'b0;
    end else begin
      if (s3_vld) begin
        if (s3_first) begin
          acc_i   <= s3_i;
          acc_q   <= s3_q;
          acc_sat <= 1'b0;
        end else begin
          acc_i   <= nxt_i;
          acc_q   <= nxt_q;
          acc_sat <= acc_sat | nxt_sat;
        end
      end
      s4_last <= s3_vld & s3_last;
    end
  end

  // Result register: capture the finished window and pulse gateout; hold until the next result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iout    <= '0;
      qout    <= '0;
      sat     <= 1'b0;
      gateout <= 1'b0;
    end else begin
      gateout <= s4_last;
      if (s4_last) begin
        iout <= acc_i;
        qout <= acc_q;
        sat  <= acc_sat;
      end
    end
  end

endmodule

// File: tb/tb_amdemod.sv
// Directed bench for amdemod (NSLICE=4, AW=40): table of constant-input windows plus
// hand sequences for overrun, reset abort, nsamp=0 and back-to-back windows.
// Expected results are hand-computed constants.
module tb_amdemod;

  logic        clk = 1'b0;
  logic        reset;
  logic        gatein;
  logic [15:0] nsamp;
  logic [63:0] adc, cosv, sinv;
  logic [39:0] iout, qout;
  logic        gateout, busy, overrun, sat;

  int checks = 0;
  int errors = 0;

  amdemod #(.NSLICE(4), .AW(40)) dut (
    .clk     (clk),
    .reset   (reset),
    .gatein  (gatein),
    .nsamp   (nsamp),
    .adcx16  (adc),
    .locos16 (cosv),
    .losin16 (sinv),
    .iout    (iout),
    .qout    (qout),
    .gateout (gateout),
    .busy    (busy),
    .overrun (overrun),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a, c, s;
    logic [15:0] n;
    longint      ei, eq;
    logic        es;
  } vec_t;

  vec_t vt[6];

  function automatic vec_t mk(input string name, input logic [63:0] a, input logic [63:0] c,
                              input logic [63:0] s, input logic [15:0] n,
                              input longint ei, input longint eq, input logic es);
    vec_t v;
    v.name = name; v.a = a; v.c = c; v.s = s; v.n = n; v.ei = ei; v.eq = eq; v.es = es;
    return v;
  endfunction

  function automatic longint sx(input logic [39:0] v);
    return longint'($signed(v));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a window at the next edge (t0) and follows it to t0+n+6.
  // gatein is re-raised for edges t0+ovr_from .. t0+ovr_from+ovr_len-1 to provoke overruns;
  // nsamp is scrambled during capture to show it is ignored.
  task automatic run_window(input string name, input logic [15:0] n, input int ovr_from,
                            input int ovr_len, input longint ei, input longint eq, input logic es);
    int pulses = 0;
    int gcyc   = -1;
    int novr   = 0;
    gatein = 1'b1;
    nsamp  = n;
    tick();
    gatein = 1'b0;
    nsamp  = n ^ 16'h0005;
    for (int c = 0; c <= int'(n) + 6; c++) begin
      if (gateout) begin
        pulses++;
        gcyc = c;
      end
      if (overrun) novr++;
      if (c == 0) check({name, "_busy_start"}, longint'(busy), longint'(1));
      if (c == int'(n)) check({name, "_busy_end"}, longint'(busy), longint'(0));
      gatein = ((c + 1) >= ovr_from) && ((c + 1) < ovr_from + ovr_len);
      tick();
    end
    gatein = 1'b0;
    check({name, "_pulses"}, longint'(pulses), longint'(1));
    check({name, "_latency"}, longint'(gcyc), longint'(int'(n) + 4));
    check({name, "_overruns"}, longint'(novr), longint'(ovr_len));
    check({name, "_iout"}, sx(iout), ei);
    check({name, "_qout"}, sx(qout), eq);
    check({name, "_sat"}, longint'(sat), longint'(es));
  endtask

  initial begin
    int     g, o;
    longint r1i, r1q, r2i, r2q;
    int     p1, p2;

    vt[0] = mk("cos_only", {4{16'h4000}}, {4{16'h7fff}}, 64'd0, 16'd8,
               64'sd17179344896, 64'sd0, 1'b0);
    vt[1] = mk("sin_only", {4{16'h4000}}, 64'd0, {4{16'h7fff}}, 16'd8,
               64'sd0, -64'sd17179344896, 1'b0);
    vt[2] = mk("neg_mix", {4{16'hffff}}, {4{16'h7fff}}, {4{16'h8000}}, 16'd3,
               -64'sd393204, -64'sd393216, 1'b0);
    vt[3] = mk("single", {4{16'h1234}}, {4{16'h0002}}, {4{16'hfffd}}, 16'd1,
               64'sd37280, 64'sd55920, 1'b0);
    vt[4] = mk("slices", {16'd4, 16'd3, 16'd2, 16'd1}, {16'd40, 16'd30, 16'd20, 16'd10},
               {16'd5, 16'd0, 16'd0, 16'hffff}, 16'd2, 64'sd600, -64'sd38, 1'b0);
`ifdef AMDEMOD_SATURATE_EN
    vt[5] = mk("big", {4{16'h8000}}, {4{16'h8000}}, 64'd0, 16'd200,
               64'sd549755813887, 64'sd0, 1'b1);
`else
    vt[5] = mk("big", {4{16'h8000}}, {4{16'h8000}}, 64'd0, 16'd200,
               -64'sd240518168576, 64'sd0, 1'b0);
`endif

    // Reset state
    reset  = 1'b1;
    gatein = 1'b0;
    nsamp  = 16'd0;
    adc    = '0;
    cosv   = '0;
    sinv   = '0;
    tick();
    tick();
    check("rst_iout", sx(iout), 64'sd0);
    check("rst_qout", sx(qout), 64'sd0);
    check("rst_gateout", longint'(gateout), longint'(0));
    check("rst_busy", longint'(busy), longint'(0));
    check("rst_overrun", longint'(overrun), longint'(0));
    check("rst_sat", longint'(sat), longint'(0));
    reset = 1'b0;

    // Table of constant-input windows
    for (int i = 0; i < 6; i++) begin
      adc  = vt[i].a;
      cosv = vt[i].c;
      sinv = vt[i].s;
      run_window(vt[i].name, vt[i].n, 0, 0, vt[i].ei, vt[i].eq, vt[i].es);
    end

    // gatein held for edges t0+2..t0+4 of an 8-sample window
    adc  = {4{16'h4000}};
    cosv = {4{16'h7fff}};
    sinv = 64'd0;
    run_window("overrun", 16'd8, 2, 3, 64'sd17179344896, 64'sd0, 1'b0);

    // Reset lands between t0+2 and t0+3 of an 8-sample window
    gatein = 1'b1;
    nsamp  = 16'd8;
    tick();
    gatein = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_iout", sx(iout), 64'sd0);
    check("abort_qout", sx(qout), 64'sd0);
    check("abort_busy", longint'(busy), longint'(0));
    check("abort_gateout", longint'(gateout), longint'(0));
    g = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (gateout) g++;
    end
    check("abort_no_gateout", longint'(g), longint'(0));
    reset = 1'b0;
    adc  = {16'd4, 16'd3, 16'd2, 16'd1};
    cosv = {16'd40, 16'd30, 16'd20, 16'd10};
    sinv = {16'd5, 16'd0, 16'd0, 16'hffff};
    run_window("post_reset", 16'd1, 0, 0, 64'sd300, -64'sd19, 1'b0);

    // nsamp=0 request is ignored
    gatein = 1'b1;
    nsamp  = 16'd0;
    tick();
    gatein = 1'b0;
    check("zero_busy", longint'(busy), longint'(0));
    g = 0;
    o = 0;
    for (int c = 0; c < 8; c++) begin
      if (gateout) g++;
      if (overrun) o++;
      if (busy) g++;
      tick();
    end
    check("zero_no_activity", longint'(g), longint'(0));
    check("zero_no_overrun", longint'(o), longint'(0));

    // Two nsamp=4 windows with a one-cycle gap: t0 and t0+5
    adc    = {4{16'h0100}};
    cosv   = {4{16'h0100}};
    sinv   = {4{16'h0010}};
    gatein = 1'b1;
    nsamp  = 16'd4;
    tick();
    gatein = 1'b0;
    p1 = -1; p2 = -1; g = 0; o = 0;
    r1i = 0; r1q = 0; r2i = 0; r2q = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (overrun) o++;
      if (gateout) begin
        g++;
        if (p1 < 0) begin
          p1 = c; r1i = sx(iout); r1q = sx(qout);
        end else begin
          p2 = c; r2i = sx(iout); r2q = sx(qout);
        end
      end
      if (c == 5) check("b2b_busy_second", longint'(busy), longint'(1));
      gatein = (c == 4);
      if (c == 4) adc = {4{16'hff00}};
    end
    gatein = 1'b0;
    check("b2b_pulses", longint'(g), longint'(2));
    check("b2b_overrun", longint'(o), longint'(0));
    check("b2b_lat1", longint'(p1), longint'(8));
    check("b2b_lat2", longint'(p2), longint'(13));
    check("b2b_i1", r1i, 64'sd1048576);
    check("b2b_q1", r1q, -64'sd65536);
    check("b2b_i2", r2i, -64'sd1048576);
    check("b2b_q2", r2q, 64'sd65536);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
